i2c_reg_sequencer: RTL and testbench
====================================

# i2c_reg_sequencer

Register-access sequencer that drives the `i2c_master_axil` core over its AXI-Lite slave port, so fabric logic can do single-byte I2C register reads and writes without a processor. It accepts one request at a time (device address, register address, write data, direction) and expands it into the core's data, command and status register accesses. It polls for completion and returns read data plus an error code. In the design it sits in place of, or muxed ahead of, the processor's M00 AXI-Lite master.

## Interface
Parameters:
- `PRESCALE`, 250: value written to the core's prescale register after reset (100 MHz, 100 kHz SCL).
- `TIMEOUT_CYCLES`, 1000000: clocks allowed from first status poll to completion before timeout error.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, shared with the core.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_rnw` in 1: 1 = read, 0 = write.
- `req_dev` in 7: I2C 7-bit device address.
- `req_reg` in 8: device register address.
- `req_wdata` in 8: write data, ignored on read.
- `rsp_valid` out 1: response valid, held until `rsp_ready`.
- `rsp_ready` in 1: response consumer ready.
- `rsp_rdata` out 8: read data; 0 on write or on error.
- `rsp_err` out 2: 0 ok, 1 NACK (missed_ack), 2 timeout, 3 AXI SLVERR/DECERR.
- `m_axil_awaddr` out 4, `m_axil_awprot` out 3 (always 0), `m_axil_awvalid` out 1, `m_axil_awready` in 1.
- `m_axil_wdata` out 32, `m_axil_wstrb` out 4 (always 4'hF), `m_axil_wvalid` out 1, `m_axil_wready` in 1.
- `m_axil_bresp` in 2, `m_axil_bvalid` in 1, `m_axil_bready` out 1.
- `m_axil_araddr` out 4, `m_axil_arprot` out 3 (always 0), `m_axil_arvalid` out 1, `m_axil_arready` in 1.
- `m_axil_rdata` in 32, `m_axil_rresp` in 2, `m_axil_rvalid` in 1, `m_axil_rready` out 1.

## Operation
- Core register map: 0x0 status, 0x4 command, 0x8 data, 0xC prescale.
  - Status bits: [0] busy, [3] missed_ack, [8] cmd_empty.
  - Command bits: [6:0] addr, [8] start, [9] read, [11] write_multiple, [12] stop.
  - Data bits: [7:0] data, [8] valid on read, [9] last on write.
  - Writing 0x8 to status clears missed_ack.
- States: INIT, IDLE, WR_REG, WR_DATA, CMD_W, CMD_R, POLL, RD_DATA, CLR_ACK, RESP.
- INIT writes `PRESCALE` to 0xC, then goes to IDLE.
- IDLE:
  - `req_ready`=1 only in IDLE.
  - On handshake, latch the request fields.
  - Go to WR_REG.
- Write request sequence:
  - data ← reg.
  - data ← 0x200|wdata.
  - cmd ← 0x1900|dev (start, write_multiple, stop).
  - POLL.
- Read request sequence:
  - data ← 0x200|reg.
  - cmd ← 0x0900|dev (no stop; repeated start follows).
  - cmd ← 0x1300|dev (start, read, stop).
  - POLL.
  - If ok, RD_DATA: read 0x8; `rsp_rdata`=rdata[7:0]. rdata[8]=0 is treated as NACK.
- POLL:
  - Read status back-to-back.
  - Done when busy=0 and cmd_empty=1.
  - If missed_ack=1 at done: go to CLR_ACK, then RESP with err 1.
  - If the timeout counter reaches `TIMEOUT_CYCLES`: go to CLR_ACK, then RESP with err 2. No data read.
- Any bresp/rresp ≠ 0:
  - Abort the remaining writes and go directly to RESP with err 3.
  - The core's FIFOs are not flushed.
- RESP: assert `rsp_valid` until `rsp_ready`, then return to IDLE.
- AXI rule: one outstanding access.
  - Write: AW and W raised in the same cycle; each dropped independently on its ready; `bready`=1 until `bvalid`.
  - Read: `arvalid` until `arready`, then `rready`=1 until `rvalid`.

## Timing
- Reset values:
  - All valid/ready outputs 0.
  - `rsp_rdata`=0, `rsp_err`=0, address/data outputs 0.
  - State=INIT.
- `req_ready` is not asserted until the INIT write's `bvalid` has been seen.
- Each AXI write takes a minimum of 2 cycles (AW/W accept, then B). Each AXI read takes a minimum of 2 cycles.
- Write request overhead: 3 writes plus polls plus 1 cycle to RESP. Read request overhead: 3 writes, polls, 1 read.
- `rsp_valid` rises the cycle after the last AXI completion. The next `req_ready` comes one cycle after the `rsp` handshake, so back-to-back requests have at least 1 idle cycle.
- `req_valid` asserted during INIT waits; it is not dropped.
- `rst` mid-transaction:
  - All AXI valids drop the next cycle, with no completion of pending handshakes.
  - INIT is re-run. The I2C core is assumed to be reset by the same `rst`.
- Timeout counter: 20+ bits, cleared on POLL entry, saturates.

## Structure
- Package `i2c_seq_pkg` holds:
  - register offsets;
  - command/data/status bit-position constants;
  - the `rsp_err` enum (OK, NACK, TIMEOUT, AXIERR);
  - the state enum.
- Sub-module `axil_single_master`:
  - One-shot AXI-Lite access engine with inputs start, rnw, addr, wdata and outputs done, rdata, resp.
  - The sequencer FSM issues one op per state.

## Test plan
- Reset → exactly one write of 250 to 0xC before `req_ready`=1; the AXI valid outputs stay 0 across `rst`.
- Write dev 0x50, reg 0x10, data 0xA5 → AXI writes 0x8←0x10, 0x8←0x2A5, 0x4←0x1950. Status returns busy=1 twice, then idle → `rsp_err`=0.
- Read dev 0x50, reg 0x10; model returns data 0x13C → writes 0x8←0x210, 0x4←0x0950, 0x4←0x1350; `rsp_rdata`=0x3C, `rsp_err`=0.
- Status returns missed_ack=1 → 0x0←0x8 is written; `rsp_err`=1, `rsp_rdata`=0, no data read.
- Busy stuck at 1 with `TIMEOUT_CYCLES`=100 → `rsp_err`=2 within 100+4 cycles of POLL entry.
- bresp=2 on the second write → no further writes, `rsp_err`=3. Also: `rsp_ready` held low for 10 cycles → `rsp_valid` held, `req_ready` stays 0.

Source files
------------

// File: rtl/i2c_reg_sequencer_pkg.sv
// i2c_seq_pkg: shared constants for the I2C register-access sequencer.
//   - i2c_master_axil core register offsets and bit positions
//   - response error codes
//   - sequencer state encoding
//   - helpers that build the core's command and data words
package i2c_seq_pkg;

  localparam logic [3:0] REG_STATUS   = 4'h0;
  localparam logic [3:0] REG_CMD      = 4'h4;
  localparam logic [3:0] REG_DATA     = 4'h8;
  localparam logic [3:0] REG_PRESCALE = 4'hC;

  localparam int STS_BUSY       = 0;
  localparam int STS_MISSED_ACK = 3;
  localparam int STS_CMD_EMPTY  = 8;

  localparam int CMD_START   = 8;
  localparam int CMD_READ    = 9;
  localparam int CMD_WR_MULT = 11;
  localparam int CMD_STOP    = 12;

  localparam int DATA_VALID = 8;
  localparam int DATA_LAST  = 9;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_AXI     = 2'd3
  } rsp_err_e;

  localparam logic [3:0] ST_INIT    = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_WR_REG  = 4'd2;
  localparam logic [3:0] ST_WR_DATA = 4'd3;
  localparam logic [3:0] ST_CMD_W   = 4'd4;
  localparam logic [3:0] ST_CMD_R   = 4'd5;
  localparam logic [3:0] ST_POLL    = 4'd6;
  localparam logic [3:0] ST_RD_DATA = 4'd7;
  localparam logic [3:0] ST_CLR_ACK = 4'd8;
  localparam logic [3:0] ST_RESP    = 4'd9;

  function automatic logic [31:0] cmd_word(logic [6:0] dev, logic start, logic rd,
                                           logic wr_mult, logic stop);
    logic [31:0] w;
    w              = '0;
    w[6:0]         = dev;
    w[CMD_START]   = start;
    w[CMD_READ]    = rd;
    w[CMD_WR_MULT] = wr_mult;
    w[CMD_STOP]    = stop;
    return w;
  endfunction

  function automatic logic [31:0] data_word(logic [7:0] b, logic last);
    logic [31:0] w;
    w            = '0;
    w[7:0]       = b;
    w[DATA_LAST] = last;
    return w;
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// i2c_reg_sequencer_if: AXI-Lite bus between the sequencer (master) and the
// i2c_master_axil core (slave). 4-bit address, 32-bit data.
//   master modport: drives AW/W/AR channels and B/R ready
//   slave modport : drives channel readies, B and R responses
interface i2c_reg_sequencer_if;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/i2c_reg_sequencer_axil_single_master.sv
// axil_single_master: one-shot AXI-Lite access engine, one access in flight.
//   clk, rst : clock, synchronous active-high reset
//   start    : launch an access (only while idle)
//   rnw      : 1 = read, 0 = write
//   addr     : register offset; wdata: write data
//   done     : completion strobe, high in the B/R handshake cycle
//   rdata    : read data (valid with done on reads)
//   resp     : bresp/rresp of the completing access
//   m_axil   : AXI-Lite master port
module axil_single_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rnw,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  i2c_reg_sequencer_if.master m_axil
);

  logic        aw_v, w_v, b_r, ar_v, r_r;
  logic [3:0]  awaddr_q, araddr_q;
  logic [31:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_v     <= 1'b0;
      w_v      <= 1'b0;
      b_r      <= 1'b0;
      ar_v     <= 1'b0;
      r_r      <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      if (start) begin
        if (rnw) begin
          araddr_q <= addr;
          ar_v     <= 1'b1;
        end else begin
          awaddr_q <= addr;
          wdata_q  <= wdata;
          aw_v     <= 1'b1;
          w_v      <= 1'b1;
          b_r      <= 1'b1;
        end
      end
      if (aw_v && m_axil.awready) aw_v <= 1'b0;
      if (w_v && m_axil.wready)   w_v  <= 1'b0;
      if (b_r && m_axil.bvalid)   b_r  <= 1'b0;
      if (ar_v && m_axil.arready) begin
        ar_v <= 1'b0;
        r_r  <= 1'b1;
      end
      if (r_r && m_axil.rvalid)   r_r  <= 1'b0;
    end
  end

  // Completion is combinational so the sequencer can advance in the
  // handshake cycle itself.
  assign done  = (b_r && m_axil.bvalid) || (r_r && m_axil.rvalid);
  assign resp  = r_r ? m_axil.rresp : m_axil.bresp;
  assign rdata = m_axil.rdata;

  assign m_axil.awaddr  = awaddr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = aw_v;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = 4'hF;
  assign m_axil.wvalid  = w_v;
  assign m_axil.bready  = b_r;
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = ar_v;
  assign m_axil.rready  = r_r;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: expands single-byte I2C register read/write requests
// into i2c_master_axil register accesses, polls for completion and returns
// read data plus an error code.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake; req_rnw, req_dev, req_reg, req_wdata
//   rsp_valid/rsp_ready : response handshake; rsp_rdata, rsp_err
//   m_axil              : AXI-Lite master port to the core
//
// state      | meaning
// INIT       | write PRESCALE to the prescale register
// IDLE       | ready for a request
// WR_REG     | data <- register address (last bit set on reads)
// WR_DATA    | data <- write byte with last bit
// CMD_W      | cmd <- start+write_multiple (+stop on writes)
// CMD_R      | cmd <- start+read+stop
// POLL       | read status until idle, NACK or timeout
// RD_DATA    | read back the received byte
// CLR_ACK    | clear missed_ack in status
// RESP       | hold response until consumed
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int PRESCALE       = 250,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  i2c_reg_sequencer_if.master m_axil
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
  localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_CYCLES);

  logic [3:0]    state, seq_next;
  logic          rnw_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q, wdata_q, rdata_q;
  rsp_err_e      err_q;
  logic          op_pend, op_state, op_start, op_rnw, op_done;
  logic [3:0]    op_addr;
  logic [31:0]   op_wdata, op_rdata;
  logic [1:0]    op_resp;
  logic [TW-1:0] timer;
  logic          timed_out, axi_err, poll_idle;
  logic          unused_rdata;

  always_comb begin
    op_state = 1'b1;
    op_rnw   = 1'b0;
    op_addr  = REG_STATUS;
    op_wdata = '0;
    seq_next = ST_POLL;
    case (state)
      ST_INIT: begin
        op_addr  = REG_PRESCALE;
        op_wdata = 32'(PRESCALE);
      end
      ST_WR_REG: begin
        op_addr  = REG_DATA;
        op_wdata = data_word(reg_q, rnw_q);
        seq_next = rnw_q ? ST_CMD_W : ST_WR_DATA;
      end
      ST_WR_DATA: begin
        op_addr  = REG_DATA;
        op_wdata = data_word(wdata_q, 1'b1);
        seq_next = ST_CMD_W;
      end
      ST_CMD_W: begin
        // Reads omit stop here so the read command issues a repeated start.
        op_addr  = REG_CMD;
        op_wdata = cmd_word(dev_q, 1'b1, 1'b0, 1'b1, !rnw_q);
        seq_next = rnw_q ? ST_CMD_R : ST_POLL;
      end
      ST_CMD_R: begin
        op_addr  = REG_CMD;
        op_wdata = cmd_word(dev_q, 1'b1, 1'b1, 1'b0, 1'b1);
      end
      ST_POLL: op_rnw = 1'b1;
      ST_RD_DATA: begin
        op_rnw  = 1'b1;
        op_addr = REG_DATA;
      end
      ST_CLR_ACK: op_wdata[STS_MISSED_ACK] = 1'b1;
      default: op_state = 1'b0;
    endcase
  end

  assign timed_out = (timer >= TIMEOUT_TC);
  // No new poll once the budget is spent; an in-flight poll is allowed to finish.
  assign op_start  = op_state && !op_pend && !((state == ST_POLL) && timed_out);
  assign axi_err   = op_done && (op_resp != 2'b00);
  assign poll_idle = !op_rdata[STS_BUSY] && op_rdata[STS_CMD_EMPTY];
  assign unused_rdata = ^op_rdata[31:9];

  axil_single_master u_axil (
    .clk    (clk),
    .rst    (rst),
    .start  (op_start),
    .rnw    (op_rnw),
    .addr   (op_addr),
    .wdata  (op_wdata),
    .done   (op_done),
    .rdata  (op_rdata),
    .resp   (op_resp),
    .m_axil (m_axil)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      op_pend <= 1'b0;
      timer   <= '0;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      if (op_start)     op_pend <= 1'b1;
      else if (op_done) op_pend <= 1'b0;
      if (timer != '1) timer <= timer + 1'b1;
      case (state)
        ST_INIT: if (op_done) state <= ST_IDLE;
        ST_IDLE: begin
          if (req_valid) begin
            rnw_q   <= req_rnw;
            dev_q   <= req_dev;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            state   <= ST_WR_REG;
          end
        end
        ST_WR_REG, ST_WR_DATA, ST_CMD_W, ST_CMD_R: begin
          if (axi_err) begin
            err_q <= ERR_AXI;
            state <= ST_RESP;
          end else if (op_done) begin
            timer <= '0;
            state <= seq_next;
          end
        end
        ST_POLL: begin
          if (axi_err) begin
            err_q <= ERR_AXI;
            state <= ST_RESP;
          end else if (op_done) begin
            if (poll_idle) begin
              if (op_rdata[STS_MISSED_ACK]) begin
                err_q <= ERR_NACK;
                state <= ST_CLR_ACK;
              end else begin
                state <= rnw_q ? ST_RD_DATA : ST_RESP;
              end
            end else if (timed_out) begin
              err_q <= ERR_TIMEOUT;
              state <= ST_CLR_ACK;
            end
          end else if (!op_pend && timed_out) begin
            err_q <= ERR_TIMEOUT;
            state <= ST_CLR_ACK;
          end
        end
        ST_RD_DATA: begin
          if (axi_err) begin
            err_q <= ERR_AXI;
            state <= ST_RESP;
          end else if (op_done) begin
            if (op_rdata[DATA_VALID]) rdata_q <= op_rdata[7:0];
            else                      err_q   <= ERR_NACK;
            state <= ST_RESP;
          end
        end
        ST_CLR_ACK: begin
          if (op_done) begin
            if (op_resp != 2'b00) err_q <= ERR_AXI;
            state <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural i2c_master_axil
// register model acting on the falling clock edge.
module tb_i2c_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rnw = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0, req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;

  always #5 clk = ~clk;

  i2c_reg_sequencer_if axil();

  i2c_reg_sequencer #(.PRESCALE(250), .TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rnw   (req_rnw),
    .req_dev   (req_dev),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_axil    (axil)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // core model state
  int          busy_left = 0;
  logic [31:0] idle_status = 32'h100;
  bit          stuck = 1'b0;
  logic [31:0] data_val = '0;
  int          wr_count = 0;
  int          err_wr_idx = 0;
  bit          b_pend = 1'b0, r_pend = 1'b0;
  logic [1:0]  b_pend_resp = '0;
  logic [31:0] r_pend_data = '0;

  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [3:0]  rd_addr[$];
  int          rd_cyc[$];

  initial begin
    axil.awready = 1'b1;
    axil.wready  = 1'b1;
    axil.arready = 1'b1;
    axil.bvalid  = 1'b0;
    axil.bresp   = 2'b00;
    axil.rvalid  = 1'b0;
    axil.rresp   = 2'b00;
    axil.rdata   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axil.bvalid = 1'b0;
        axil.rvalid = 1'b0;
        b_pend = 1'b0;
        r_pend = 1'b0;
      end else begin
        axil.bvalid = b_pend;
        axil.bresp  = b_pend_resp;
        axil.rvalid = r_pend;
        axil.rdata  = r_pend_data;
        b_pend = 1'b0;
        r_pend = 1'b0;
        if (axil.awvalid && axil.wvalid) begin
          wr_addr.push_back(axil.awaddr);
          wr_data.push_back(axil.wdata);
          wr_cyc.push_back(cyc);
          wr_count++;
          b_pend = 1'b1;
          b_pend_resp = (wr_count == err_wr_idx) ? 2'd2 : 2'd0;
        end
        if (axil.arvalid) begin
          rd_addr.push_back(axil.araddr);
          rd_cyc.push_back(cyc);
          r_pend = 1'b1;
          if (axil.araddr == 4'h8) r_pend_data = data_val;
          else if (stuck) r_pend_data = 32'h1;
          else if (busy_left > 0) begin
            busy_left--;
            r_pend_data = 32'h1;
          end else r_pend_data = idle_status;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    wr_count = 0;
  endtask

  task automatic do_req(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, output bit got);
    int n;
    @(negedge clk);
    req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    got = rsp_valid;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    int n;
    rst = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (axil.awvalid | axil.wvalid | axil.arvalid | axil.bready | axil.rready |
          req_ready | rsp_valid) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL rst_valids: got active valid/ready in reset, required all 0"); end
    checks++;
    if ({rsp_rdata, rsp_err, axil.awaddr, axil.araddr, axil.wdata} !== '0) begin
      failures++;
      $display("FAIL rst_data: rdata=%0h err=%0d awaddr=%0h araddr=%0h wdata=%0h required 0",
               rsp_rdata, rsp_err, axil.awaddr, axil.araddr, axil.wdata);
    end
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL init_ready: req_ready=%b required 1", req_ready); end
    checks++;
    if (!(wr_addr.size() == 1 && wr_addr[0] == 4'hC && wr_data[0] == 32'd250 && rd_addr.size() == 0)) begin
      failures++;
      $display("FAIL init_write: %0d writes first addr=%0h data=%0d, required 1 write 0xC<-250",
               wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 4'h0, wr_data.size() > 0 ? wr_data[0] : 0);
    end
  endtask

  task automatic test_write();
    bit got, ok;
    logic [3:0]  ea [3] = '{4'h8, 4'h8, 4'h4};
    logic [31:0] ed [3] = '{32'h10, 32'h2A5, 32'h1950};
    clear_log();
    busy_left = 2; idle_status = 32'h100; stuck = 1'b0; err_wr_idx = 0;
    do_req(1'b0, 7'h50, 8'h10, 8'hA5, got);
    checks++;
    if (got !== 1'b1) begin failures++; $display("FAIL wr_rsp: no response"); end
    ok = (wr_addr.size() == 3);
    for (int i = 0; i < 3; i++) if (ok && (wr_addr[i] != ea[i] || wr_data[i] != ed[i])) ok = 1'b0;
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL wr_seq: %0d writes, required 8<-10, 8<-2A5, 4<-1950", wr_addr.size()); end
    checks++;
    if (rd_addr.size() != 3 || rd_addr[2] != 4'h0) begin
      failures++; $display("FAIL wr_polls: %0d reads, required 3 status polls", rd_addr.size());
    end
    checks++;
    if (rsp_err !== 2'd0 || rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL wr_result: err=%0d rdata=%0h required err=0 rdata=0", rsp_err, rsp_rdata);
    end
    ack_rsp();
  endtask

  task automatic test_read();
    bit got, ok;
    logic [3:0]  ea [3] = '{4'h8, 4'h4, 4'h4};
    logic [31:0] ed [3] = '{32'h210, 32'h0950, 32'h1350};
    clear_log();
    busy_left = 1; idle_status = 32'h100; data_val = 32'h13C;
    do_req(1'b1, 7'h50, 8'h10, 8'h00, got);
    checks++;
    if (got !== 1'b1) begin failures++; $display("FAIL rd_rsp: no response"); end
    ok = (wr_addr.size() == 3);
    for (int i = 0; i < 3; i++) if (ok && (wr_addr[i] != ea[i] || wr_data[i] != ed[i])) ok = 1'b0;
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL rd_seq: %0d writes, required 8<-210, 4<-950, 4<-1350", wr_addr.size()); end
    checks++;
    if (rd_addr.size() != 3 || rd_addr[2] != 4'h8) begin
      failures++; $display("FAIL rd_reads: %0d reads, required 2 polls then data read", rd_addr.size());
    end
    checks++;
    if (rsp_rdata !== 8'h3C || rsp_err !== 2'd0) begin
      failures++; $display("FAIL rd_result: rdata=%0h err=%0d required rdata=3C err=0", rsp_rdata, rsp_err);
    end
    ack_rsp();
  endtask

  task automatic test_nack();
    bit got, data_read;
    clear_log();
    busy_left = 0; idle_status = 32'h108; data_val = 32'h1FF;
    do_req(1'b1, 7'h21, 8'h33, 8'h00, got);
    data_read = 1'b0;
    foreach (rd_addr[i]) if (rd_addr[i] == 4'h8) data_read = 1'b1;
    checks++;
    if (!(got && wr_addr.size() == 4 && wr_addr[3] == 4'h0 && wr_data[3] == 32'h8)) begin
      failures++; $display("FAIL nack_clear: %0d writes, required 4 ending 0<-8", wr_addr.size());
    end
    checks++;
    if (data_read !== 1'b0) begin failures++; $display("FAIL nack_noread: data register read, required none"); end
    checks++;
    if (rsp_err !== 2'd1 || rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL nack_result: err=%0d rdata=%0h required err=1 rdata=0", rsp_err, rsp_rdata);
    end
    ack_rsp();
    idle_status = 32'h100;
  endtask

  task automatic test_timeout();
    bit got, data_read;
    int lat;
    clear_log();
    stuck = 1'b1; data_val = 32'h155;
    do_req(1'b1, 7'h50, 8'h10, 8'h00, got);
    data_read = 1'b0;
    foreach (rd_addr[i]) if (rd_addr[i] == 4'h8) data_read = 1'b1;
    checks++;
    if (!(got && rsp_err === 2'd2 && rsp_rdata === 8'h00)) begin
      failures++; $display("FAIL to_result: got=%b err=%0d rdata=%0h required err=2 rdata=0", got, rsp_err, rsp_rdata);
    end
    checks++;
    if (!(wr_addr.size() == 4 && wr_addr[3] == 4'h0 && wr_data[3] == 32'h8) || data_read) begin
      failures++; $display("FAIL to_clear: %0d writes, data_read=%b, required clear write and no data read", wr_addr.size(), data_read);
    end
    lat = (wr_cyc.size() == 4 && rd_cyc.size() > 0) ? wr_cyc[3] - rd_cyc[0] : -1;
    checks++;
    if (lat < 99 || lat > 103) begin
      failures++; $display("FAIL to_latency: first poll to clear write %0d cycles, required 99..103", lat);
    end
    ack_rsp();
    stuck = 1'b0;
  endtask

  task automatic test_axi_err_hold();
    bit got, bad;
    clear_log();
    busy_left = 0; err_wr_idx = 2;
    do_req(1'b0, 7'h50, 8'h10, 8'hA5, got);
    checks++;
    if (!(got && wr_addr.size() == 2 && rd_addr.size() == 0)) begin
      failures++; $display("FAIL axi_abort: %0d writes %0d reads, required 2 writes 0 reads", wr_addr.size(), rd_addr.size());
    end
    checks++;
    if (rsp_err !== 2'd3 || rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL axi_result: err=%0d rdata=%0h required err=3 rdata=0", rsp_err, rsp_rdata);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL rsp_hold: rsp_valid dropped or req_ready rose while rsp_ready low"); end
    ack_rsp();
    err_wr_idx = 0;
  endtask

  task automatic test_back_to_back();
    bit got;
    clear_log();
    busy_left = 0; data_val = 32'h1A5;
    do_req(1'b1, 7'h10, 8'h02, 8'h00, got);
    checks++;
    if (!(got && req_ready === 1'b0 && rsp_rdata === 8'hA5 && rsp_err === 2'd0)) begin
      failures++; $display("FAIL b2b_first: got=%b req_ready=%b rdata=%0h err=%0d required 1,0,A5,0", got, req_ready, rsp_rdata, rsp_err);
    end
    ack_rsp();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_ready: req_ready=%b rsp_valid=%b required 1,0", req_ready, rsp_valid);
    end
    data_val = 32'h07F;
    do_req(1'b1, 7'h10, 8'h03, 8'h00, got);
    checks++;
    if (!(got && rsp_err === 2'd1 && rsp_rdata === 8'h00)) begin
      failures++; $display("FAIL rd_invalid: err=%0d rdata=%0h required err=1 rdata=0", rsp_err, rsp_rdata);
    end
    ack_rsp();
  endtask

  task automatic test_rst_mid();
    int n;
    clear_log();
    busy_left = 0;
    @(negedge clk);
    req_rnw = 1'b0; req_dev = 7'h50; req_reg = 8'h44; req_wdata = 8'h12; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!axil.awvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (axil.awvalid !== 1'b1) begin failures++; $display("FAIL rstmid_start: awvalid=%b required 1", axil.awvalid); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready, req_ready, rsp_valid} !== 7'b0) begin
      failures++;
      $display("FAIL rstmid_drop: aw=%b w=%b ar=%b b=%b r=%b required all 0",
               axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready);
    end
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!(req_ready && wr_addr.size() == 1 && wr_addr[0] == 4'hC && wr_data[0] == 32'd250)) begin
      failures++; $display("FAIL rstmid_init: req_ready=%b writes=%0d required INIT re-run 0xC<-250", req_ready, wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_axi_err_hold();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
